// File: rtl/ped_signal.sv
// ped_signal: pedestrian Walk/DontWalk controller that follows the lamps of
// a traffic_light instance. A request latched from ped_button is served on
// the next rising edge of Red. Overlapping lamps trap the block in a sticky
// FAULT state that only reset can leave.
//
// Optional feature: define PED_COUNTDOWN_EN to drive a walk-plus-flash
// countdown on 'remaining'. Without it, 'remaining' is tied to zero.
module ped_signal #(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 6,
  parameter int FLASH_HALF   = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       Red,
  input  logic       Yellow,
  input  logic       Green,
  input  logic       ped_button,
  output logic       Walk,
  output logic       DontWalk,
  output logic       req_pending,
  output logic       fault,
  output logic [7:0] remaining
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RED,
    WALK,
    FLASH,
    FAULT
  } state_t;

  localparam logic [6:0] WALK_LAST  = 7'(WALK_CYCLES - 1);
  localparam logic [6:0] FLASH_LAST = 7'(FLASH_CYCLES - 1);
  localparam logic [3:0] HALF_LAST  = 4'(FLASH_HALF - 1);

  state_t     state;
  state_t     state_n;
  logic       red_s;
  logic       yel_s;
  logic       grn_s;
  logic       red_d;
  logic       red_rise;
  logic       lamp_fault;
  logic [6:0] cnt;
  logic [6:0] cnt_n;
  logic [3:0] half_cnt;
  logic [3:0] half_n;
  logic       flash_dw_n;
  logic       pend_n;

  assign red_rise   = red_s & ~red_d;
  assign lamp_fault = (red_s & yel_s) | (red_s & grn_s) | (yel_s & grn_s);

  // Sample the lamps once per cycle and keep a delayed copy of Red for edge detection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      red_s <= 1'b0;
      yel_s <= 1'b0;
      grn_s <= 1'b0;
      red_d <= 1'b0;
    end else begin
      red_s <= Red;
      yel_s <= Yellow;
      grn_s <= Green;
      red_d <= red_s;
    end
  end

  // Next-state, phase counters, flash phase and request latch for the coming edge.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    half_n     = half_cnt;
    flash_dw_n = DontWalk;
    pend_n     = req_pending;

    if (ped_button && (state == IDLE || state == WAIT_RED || state == FLASH)) begin
      pend_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (ped_button) begin
          state_n = WAIT_RED;
        end
      end
      WAIT_RED: begin
        if (red_rise) begin
          state_n = WALK;
          pend_n  = 1'b0;
          cnt_n   = WALK_LAST;
        end
      end
      WALK: begin
        if (!red_s) begin
          state_n = pend_n ? WAIT_RED : IDLE;
        end else if (cnt == 7'd0) begin
          state_n    = FLASH;
          cnt_n      = FLASH_LAST;
          half_n     = 4'd0;
          flash_dw_n = 1'b1;
        end else begin
          cnt_n = cnt - 7'd1;
        end
      end
      FLASH: begin
        if (!red_s || cnt == 7'd0) begin
          state_n = pend_n ? WAIT_RED : IDLE;
        end else begin
          cnt_n = cnt - 7'd1;
          if (half_cnt == HALF_LAST) begin
            half_n     = 4'd0;
            flash_dw_n = ~DontWalk;
          end else begin
            half_n = half_cnt + 4'd1;
          end
        end
      end
      FAULT: begin
        // No crossing can be served from FAULT, so an old request is dropped.
        pend_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (lamp_fault) begin
      state_n = FAULT;
      pend_n  = 1'b0;
    end

    if (state_n != WALK && state_n != FLASH) begin
      cnt_n  = 7'd0;
      half_n = 4'd0;
    end
  end

  // State register with outputs registered from the next state so Walk follows the red rise by one edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= 7'd0;
      half_cnt    <= 4'd0;
      Walk        <= 1'b0;
      DontWalk    <= 1'b1;
      req_pending <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      half_cnt    <= half_n;
      Walk        <= (state_n == WALK);
      DontWalk    <= (state_n == FLASH) ? flash_dw_n : (state_n != WALK);
      req_pending <= pend_n;
      fault       <= (state_n == FAULT);
    end
  end

`ifdef PED_COUNTDOWN_EN
  localparam logic [7:0] REM_LOAD = 8'(WALK_CYCLES + FLASH_CYCLES - 1);

  // Countdown loads on entry to WALK and steps down through WALK and FLASH.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      remaining <= 8'd0;
    end else if (state_n == WALK && state != WALK) begin
      remaining <= REM_LOAD;
    end else if (state_n == WALK || state_n == FLASH) begin
      remaining <= remaining - 8'd1;
    end else begin
      remaining <= 8'd0;
    end
  end
`else
  assign remaining = 8'd0;
`endif

endmodule

// File: tb/tb_ped_signal.sv
// tb_ped_signal: directed bench for ped_signal with a cycle-level behavioural
// model and literal spot checks. Honours PED_COUNTDOWN_EN for 'remaining'.
module tb_ped_signal;

  localparam int W = 8;
  localparam int F = 6;
  localparam int H = 1;

  logic       clk;
  logic       rstn;
  logic       Red;
  logic       Yellow;
  logic       Green;
  logic       ped_button;
  logic       Walk;
  logic       DontWalk;
  logic       req_pending;
  logic       fault;
  logic [7:0] remaining;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 idle, 1 waiting for red, 2 crossing (t = cycles since Walk rose), 3 fault.
  int mode = 0;
  int t = 0;
  bit pend = 0;
  bit s_r1 = 0;
  bit s_r2 = 0;
  bit s_y1 = 0;
  bit s_g1 = 0;
  bit model_valid = 0;
  bit rise;
  int lamps;

  ped_signal #(
    .WALK_CYCLES (W),
    .FLASH_CYCLES(F),
    .FLASH_HALF  (H)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .Red        (Red),
    .Yellow     (Yellow),
    .Green      (Green),
    .ped_button (ped_button),
    .Walk       (Walk),
    .DontWalk   (DontWalk),
    .req_pending(req_pending),
    .fault      (fault),
    .remaining  (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model update: evaluate crossing rules on each rising edge from the lamps seen so far.
  always @(posedge clk) begin
    if (!rstn) begin
      mode = 0; t = 0; pend = 0;
      s_r1 = 0; s_r2 = 0; s_y1 = 0; s_g1 = 0;
    end else begin
      lamps = int'(s_r1) + int'(s_y1) + int'(s_g1);
      rise  = s_r1 && !s_r2;
      if (mode == 3) begin
        pend = 0;
      end else if (lamps >= 2) begin
        mode = 3;
        pend = 0;
      end else if (mode == 0) begin
        if (ped_button) begin
          pend = 1;
          mode = 1;
        end
      end else if (mode == 1) begin
        if (rise) begin
          mode = 2;
          t = 0;
          pend = 0;
        end else if (ped_button) begin
          pend = 1;
        end
      end else begin
        if (t >= W && ped_button) pend = 1;
        if (!s_r1 || t == W + F - 1) mode = pend ? 1 : 0;
        else t++;
      end
      s_r2 = s_r1;
      s_r1 = Red;
      s_y1 = Yellow;
      s_g1 = Green;
    end
    model_valid = 1;
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      int e_walk;
      int e_dw;
      int e_rem;
      e_walk = (mode == 2 && t < W) ? 1 : 0;
      e_dw   = (mode == 2) ? ((t >= W && ((t - W) / H) % 2 == 0) ? 1 : 0) : 1;
`ifdef PED_COUNTDOWN_EN
      e_rem  = (mode == 2) ? (W + F - 1 - t) : 0;
`else
      e_rem  = 0;
`endif
      check_output("model_walk", int'(Walk), e_walk);
      check_output("model_dontwalk", int'(DontWalk), e_dw);
      check_output("model_pending", int'(req_pending), int'(pend));
      check_output("model_fault", int'(fault), (mode == 3) ? 1 : 0);
      check_output("model_remaining", int'(remaining), e_rem);
    end
  end

  task automatic start_walk();
    Red = 0; Yellow = 0; Green = 1;
    step(2);
    ped_button = 1;
    step(1);
    ped_button = 0;
    Green = 0; Red = 1;
    step(2);
  endtask

  initial begin
    logic [15:0] walk_seq;
    logic [15:0] dw_seq;
    rstn = 0; Red = 0; Yellow = 0; Green = 0; ped_button = 0;
    step(2);
    check_output("rst_walk", int'(Walk), 0);
    check_output("rst_dontwalk", int'(DontWalk), 1);
    check_output("rst_pending", int'(req_pending), 0);
    check_output("rst_fault", int'(fault), 0);
    check_output("rst_remaining", int'(remaining), 0);

    // Red held with no button: nothing happens.
    rstn = 1; Red = 1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check_output("nobtn_walk", int'(Walk), 0);
      check_output("nobtn_dontwalk", int'(DontWalk), 1);
      check_output("nobtn_pending", int'(req_pending), 0);
    end
    Red = 0; Green = 1;
    step(3);

    // Full default cycle: button, yellow, red rise, walk 8, flash 6.
    ped_button = 1;
    step(1);
    ped_button = 0;
    check_output("req_latched", int'(req_pending), 1);
    Green = 0; Yellow = 1;
    step(2);
    Yellow = 0; Red = 1;
    walk_seq = 16'h01FE;
    dw_seq   = 16'hAA01;
    for (int k = 0; k < 16; k++) begin
      step(1);
      check_output("seq_walk", int'(Walk), int'(walk_seq[k]));
      check_output("seq_dontwalk", int'(DontWalk), int'(dw_seq[k]));
      if (k == 0) check_output("seq_pend_before", int'(req_pending), 1);
      if (k == 1) check_output("seq_pend_after", int'(req_pending), 0);
`ifdef PED_COUNTDOWN_EN
      if (k == 1) check_output("seq_rem_first", int'(remaining), 13);
      if (k == 14) check_output("seq_rem_last", int'(remaining), 0);
`endif
    end

    // Red drops 3 cycles into WALK.
    start_walk();
    check_output("drop_walk_on", int'(Walk), 1);
    step(2);
    Red = 0;
    step(2);
    check_output("drop_walk", int'(Walk), 0);
    check_output("drop_dontwalk", int'(DontWalk), 1);
    check_output("drop_pending", int'(req_pending), 0);
    Green = 1;
    step(2);

    // Button during FLASH: served on the next red rise only.
    start_walk();
    step(8);
    check_output("flash_walk", int'(Walk), 0);
    ped_button = 1;
    step(1);
    ped_button = 0;
    check_output("flash_pend", int'(req_pending), 1);
    step(8);
    check_output("wait_pend", int'(req_pending), 1);
    check_output("wait_walk", int'(Walk), 0);
    check_output("wait_dontwalk", int'(DontWalk), 1);
    Red = 0;
    step(2);
    Red = 1;
    step(1);
    check_output("rerise_walk_early", int'(Walk), 0);
    step(1);
    check_output("rerise_walk", int'(Walk), 1);
    check_output("rerise_pend", int'(req_pending), 0);
    step(16);
    Red = 0; Green = 1;
    step(2);

    // Request while Red already high waits for the next rise.
    Green = 0; Red = 1;
    step(3);
    ped_button = 1;
    step(1);
    ped_button = 0;
    step(4);
    check_output("redhigh_walk", int'(Walk), 0);
    check_output("redhigh_pend", int'(req_pending), 1);
    Red = 0;
    step(2);
    Red = 1;
    step(2);
    check_output("redhigh_served", int'(Walk), 1);
    step(15);

    // Red drops mid-FLASH.
    start_walk();
    step(9);
    Red = 0;
    step(3);
    check_output("flashdrop_walk", int'(Walk), 0);
    check_output("flashdrop_dontwalk", int'(DontWalk), 1);
    Green = 1;
    step(2);

    // Red and Green together mid-WALK: sticky fault until reset.
    start_walk();
    step(2);
    Green = 1;
    step(2);
    check_output("fault_set", int'(fault), 1);
    check_output("fault_walk", int'(Walk), 0);
    check_output("fault_dontwalk", int'(DontWalk), 1);
    Green = 0;
    ped_button = 1;
    step(4);
    ped_button = 0;
    check_output("fault_sticky", int'(fault), 1);
    check_output("fault_pend", int'(req_pending), 0);
    rstn = 0;
    step(1);
    rstn = 1;
    check_output("fault_cleared", int'(fault), 0);
    check_output("fault_clr_dontwalk", int'(DontWalk), 1);

    // Reset mid-FLASH discards the pending request.
    start_walk();
    step(9);
    ped_button = 1;
    step(1);
    ped_button = 0;
    check_output("rstflash_pend_set", int'(req_pending), 1);
    rstn = 0;
    step(1);
    rstn = 1;
    check_output("rstflash_pend", int'(req_pending), 0);
    check_output("rstflash_walk", int'(Walk), 0);
    check_output("rstflash_dontwalk", int'(DontWalk), 1);
    step(3);
    check_output("rstflash_idle", int'(req_pending), 0);

    // Yellow and Green together from IDLE.
    Red = 0; Yellow = 1; Green = 1;
    step(2);
    check_output("idle_fault", int'(fault), 1);
    rstn = 0;
    step(1);
    rstn = 1; Yellow = 0; Green = 0;
    step(2);
    check_output("dark_nofault", int'(fault), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ped_signal.md
PED_SIGNAL -- requirements
Module: ped_signal

Interface
REQ-001 SHALL have parameter WALK_CYCLES, default 8: cycles of solid Walk; legal range 1..127.
REQ-002 SHALL have parameter FLASH_CYCLES, default 6: cycles of flashing DontWalk; legal range 1..127.
REQ-003 SHALL have parameter FLASH_HALF, default 1: cycles per DontWalk flash half-period; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports Red, Yellow, Green  input  1 each  lamp outputs of traffic_light.
REQ-007 SHALL have port ped_button  input  1  pedestrian request, synchronous level.
REQ-008 SHALL have port Walk  output  1  pedestrian walk lamp.
REQ-009 SHALL have port DontWalk  output  1  pedestrian don't-walk lamp.
REQ-010 SHALL have port req_pending  output  1  latched request awaiting service.
REQ-011 SHALL have port fault  output  1  sticky illegal-lamp indication.
REQ-012 SHALL have port remaining  output  8  countdown of walk-plus-flash cycles left.

Function
REQ-013 SHALL register Red/Yellow/Green into red_s/yel_s/grn_s every cycle, and red_s into red_d; red rise = red_s & ~red_d.
REQ-014 SHALL implement states IDLE, WAIT_RED, WALK, FLASH, FAULT; every output SHALL be registered.
REQ-015 SHALL set req_pending when ped_button=1 in IDLE, WAIT_RED or FLASH; ped_button SHALL be ignored in WALK and FAULT.
REQ-016 IDLE -> WAIT_RED when ped_button=1.
REQ-017 WAIT_RED -> WALK on red rise; req_pending SHALL clear on that same edge.
REQ-018 A request made while Red is already high SHALL wait for the next red rise.
REQ-019 Walk SHALL rise on the second clock edge after Red is first sampled high.
REQ-020 WALK: Walk=1 and DontWalk=0 for exactly WALK_CYCLES cycles, then -> FLASH.
REQ-021 FLASH: Walk=0 for exactly FLASH_CYCLES cycles; DontWalk starts at 1 and toggles every FLASH_HALF cycles.
REQ-022 End of FLASH: -> WAIT_RED if req_pending=1, else -> IDLE.
REQ-023 In IDLE and WAIT_RED: Walk=0 and DontWalk=1 solid.
REQ-024 red_s=0 during WALK or FLASH (Red dropped early) SHALL force IDLE, or WAIT_RED if req_pending=1, on the next edge: Walk=0, DontWalk=1.
REQ-025 Two or more of red_s/yel_s/grn_s high SHALL move to FAULT on the next edge from any state.
REQ-026 In FAULT: fault=1, Walk=0, DontWalk=1; FAULT SHALL be left only by reset.
REQ-027 All three lamps low SHALL be legal and is not a fault.
REQ-028 A fault occurring together with a red rise or a timer expiry SHALL take precedence.
REQ-029 Walk and DontWalk SHALL never both be 1.

Reset
REQ-030 With rstn=0 at a clock edge, state SHALL go to IDLE: Walk=0, DontWalk=1, req_pending=0, fault=0, remaining=0, all counters and sample flops 0.
REQ-031 Reset mid-WALK or mid-FLASH SHALL abort immediately; a request pending at reset SHALL be discarded.

Configuration
REQ-032 Macro PED_COUNTDOWN_EN defined: remaining SHALL load WALK_CYCLES+FLASH_CYCLES-1 on entry to WALK and decrement each WALK/FLASH cycle.
REQ-033 PED_COUNTDOWN_EN defined: remaining SHALL be 0 in all other states.
REQ-034 PED_COUNTDOWN_EN undefined: port remaining SHALL be present and tied to 0, with no countdown logic; all other behaviour SHALL be identical.

Verification
REQ-035 Reset, then Red held high with no button -> Walk=0, DontWalk=1, req_pending=0 throughout.
REQ-036 Defaults; button pulse 1 cycle, then Red rises -> req_pending=1 until Walk rises.
REQ-037 Same run -> Walk=1 for 8 cycles, then DontWalk toggles 1,0,1,0,1,0 over 6 cycles, then IDLE; with macro, remaining counts 13 down to 0.
REQ-038 Red drops 3 cycles into WALK -> Walk=0 and DontWalk=1 within 2 edges, state IDLE.
REQ-039 Button pressed during FLASH -> req_pending stays 1; WAIT_RED after FLASH; Walk on next red rise only.
REQ-040 Red and Green high together mid-WALK -> fault=1, Walk=0, DontWalk=1 sticky through lamp recovery; rstn=0 for 1 edge clears it.
